// File: rtl/bus_wrr_scheduler_if.sv
// Bundle between the device-side FIFOs, the weight config port and the single
// output channel of bus_wrr_scheduler.
interface bus_wrr_scheduler_if #(
   parameter int DRVRS   = 4,
   parameter int PCKG_SZ = 16,
   parameter int WGT_W   = 4
);
   localparam int IW = $clog2(DRVRS);

   logic [DRVRS-1:0]         pndng;
   logic [DRVRS*PCKG_SZ-1:0] D_pop;
   logic [DRVRS-1:0]         pop;
   logic                     cfg_we;
   logic [IW-1:0]            cfg_idx;
   logic [WGT_W-1:0]         cfg_wgt;
   logic                     out_valid;
   logic                     out_ready;
   logic [PCKG_SZ-1:0]       out_data;
   logic [IW-1:0]            out_src;

   modport master (
      input  pndng, D_pop, cfg_we, cfg_idx, cfg_wgt, out_ready,
      output pop, out_valid, out_data, out_src
   );

   modport slave (
      output pndng, D_pop, cfg_we, cfg_idx, cfg_wgt, out_ready,
      input  pop, out_valid, out_data, out_src
   );
endinterface

// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin scheduler: pops one packet at a time from DRVRS FWFT
// FIFOs and presents it, tagged with its source, on one valid/ready channel.
module bus_wrr_scheduler #(
   parameter int DRVRS   = 4,
   parameter int PCKG_SZ = 16,
   parameter int WGT_W   = 4
) (
   input logic                clk,
   input logic                reset,
   bus_wrr_scheduler_if.master bus
);
   localparam int IW = $clog2(DRVRS);

   typedef enum logic [1:0] {IDLE, POP, SEND} state_t;

   state_t                       state, state_nxt;
   logic   [IW-1:0]              sel, ptr, win;
   logic   [WGT_W-1:0]           cnt, cnt_nxt;
   logic   [DRVRS-1:0][WGT_W-1:0] weight;
   logic   [DRVRS-1:0]           elig, pop_nxt;
   logic                         grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         sel          <= '0;
         ptr          <= IW'(DRVRS-1);
         cnt          <= '0;
         bus.pop      <= '0;
         bus.out_data <= '0;
         bus.out_src  <= '0;
         for (int i = 0; i < DRVRS; i++) weight[i] <= WGT_W'(1);
      end else begin
         state   <= state_nxt;
         bus.pop <= pop_nxt;
         if (grant) begin
            sel <= win;
            ptr <= win;
            cnt <= cnt_nxt;
         end
         if (state == POP) begin
            bus.out_data <= bus.D_pop[int'(sel)*PCKG_SZ +: PCKG_SZ];
            bus.out_src  <= sel;
         end
         if (bus.cfg_we && int'(bus.cfg_idx) < DRVRS)
            weight[bus.cfg_idx] <= bus.cfg_wgt;
      end
   end

   // cnt==0 means no burst is in progress, so the scan starts at ptr+1;
   // this is what lets index 0 win first out of reset.
   always_comb begin
      int   idx;
      logic found;
      idx       = 0;
      found     = 1'b0;
      state_nxt = state;
      grant     = 1'b0;
      win       = ptr;
      cnt_nxt   = cnt;
      for (int i = 0; i < DRVRS; i++) elig[i] = bus.pndng[i] && (weight[i] != '0);
      case (state)
         IDLE: if (|elig) begin
            state_nxt = POP;
            grant     = 1'b1;
            if (cnt != '0 && elig[ptr] && cnt < weight[ptr]) begin
               cnt_nxt = cnt + WGT_W'(1);
            end else begin
               cnt_nxt = WGT_W'(1);
               for (int k = 1; k < DRVRS; k++) begin
                  idx = (int'(ptr) + k) % DRVRS;
                  if (!found && elig[idx]) begin
                     found = 1'b1;
                     win   = IW'(idx);
                  end
               end
            end
         end
         POP:     state_nxt = SEND;
         SEND:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      pop_nxt = '0;
      if (grant) pop_nxt[win] = 1'b1;
      bus.out_valid = (state == SEND);
   end
endmodule

// File: tb/tb_bus_wrr_scheduler.sv
// Self-checking bench: directed grant-order table, hand-written latency,
// back-pressure, reset and config corner cases, then random traffic vs a model.
module tb_bus_wrr_scheduler;
   localparam int N = 4, PW = 16, WW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bus_wrr_scheduler_if #(.DRVRS(N), .PCKG_SZ(PW), .WGT_W(WW)) b();
   bus_wrr_scheduler #(.DRVRS(N), .PCKG_SZ(PW), .WGT_W(WW)) dut (
      .clk(clk), .reset(reset), .bus(b));

   // Non-power-of-two instance: the only way to present an out-of-range cfg_idx.
   bus_wrr_scheduler_if #(.DRVRS(3), .PCKG_SZ(PW), .WGT_W(WW)) b3();
   bus_wrr_scheduler #(.DRVRS(3), .PCKG_SZ(PW), .WGT_W(WW)) dut3 (
      .clk(clk), .reset(reset), .bus(b3));

   typedef struct packed {
      logic [3:0]  pend;
      logic [15:0] wgt;   // nibble i = weight of FIFO i
      logic [35:0] exp;   // nibble k = k-th expected source
   } vec_t;

   vec_t vecs[6];
   int checks = 0, fails = 0;
   int got_src[$];
   logic [PW-1:0] got_dat[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   task automatic wr(input int idx, input int w);
      b.cfg_we = 1'b1; b.cfg_idx = 2'(idx); b.cfg_wgt = 4'(w);
      tick();
      b.cfg_we = 1'b0;
   endtask

   task automatic set_pattern();
      for (int i = 0; i < N; i++) b.D_pop[i*PW +: PW] = 16'hC000 + 16'(i);
   endtask

   task automatic collect(input int n);
      logic [N-1:0] prev;
      prev = '0;
      got_src.delete(); got_dat.delete();
      for (int c = 0; c < 400 && got_src.size() < n; c++) begin
         tick();
         if (b.pop != '0) chk("pop_onehot_single", {63'd0, ($onehot(b.pop) && prev == '0)}, 64'd1);
         prev = b.pop;
         if (b.out_valid && b.out_ready) begin
            got_src.push_back(int'(b.out_src));
            got_dat.push_back(b.out_data);
         end
      end
      if (got_src.size() < n) chk("collect_timeout", 64'(got_src.size()), 64'(n));
   endtask

   // ---------------- reference model (transaction-level) ----------------
   int m_wgt[N];
   int m_owner, m_credit, m_phase, m_win, m_src;
   logic [PW-1:0] m_data;

   function automatic bit m_elig(input int c);
      return b.pndng[c] && m_wgt[c] > 0;
   endfunction

   task automatic m_init();
      for (int i = 0; i < N; i++) m_wgt[i] = 1;
      m_owner = N - 1; m_credit = 0; m_phase = 0; m_win = 0; m_src = 0; m_data = '0;
   endtask

   // Owner keeps the channel while its burst allowance lasts; otherwise the
   // next eligible index in rotation (wrapping back to the owner) takes over.
   task automatic m_pick(output int w);
      w = -1;
      if (m_credit > 0 && m_elig(m_owner) && m_credit < m_wgt[m_owner]) begin
         m_credit++; w = m_owner;
      end else begin
         for (int off = 1; off <= N && w < 0; off++)
            if (m_elig((m_owner + off) % N)) begin
               m_owner = (m_owner + off) % N; m_credit = 1; w = m_owner;
            end
      end
   endtask

   task automatic m_step(output logic [N-1:0] ep, output logic ev);
      bit any;
      ep = '0; ev = 1'b0; any = 1'b0;
      for (int i = 0; i < N; i++) if (m_elig(i)) any = 1'b1;
      case (m_phase)
         0: if (any) begin m_pick(m_win); ep[m_win] = 1'b1; m_phase = 1; end
         1: begin
            m_data = b.D_pop[m_win*PW +: PW]; m_src = m_win; m_phase = 2; ev = 1'b1;
         end
         default: if (b.out_ready) m_phase = 0; else ev = 1'b1;
      endcase
      if (b.cfg_we) m_wgt[int'(b.cfg_idx)] = int'(b.cfg_wgt);
   endtask

   initial begin
      logic [35:0] e;
      logic [N-1:0] ep;
      logic ev;
      int waitc;

      vecs[0] = '{pend: 4'hF, wgt: 16'h1111, exp: 36'h032103210};
      vecs[1] = '{pend: 4'hF, wgt: 16'h1113, exp: 36'h000321000};
      vecs[2] = '{pend: 4'hF, wgt: 16'h1011, exp: 36'h310310310};
      vecs[3] = '{pend: 4'hF, wgt: 16'h0102, exp: 36'h200200200};
      vecs[4] = '{pend: 4'hA, wgt: 16'h1111, exp: 36'h131313131};
      vecs[5] = '{pend: 4'h8, wgt: 16'h3111, exp: 36'h333333333};

      reset = 1'b1;
      b.pndng = '0; b.D_pop = '0; b.cfg_we = 1'b0; b.cfg_idx = '0; b.cfg_wgt = '0; b.out_ready = 1'b0;
      b3.pndng = '0; b3.D_pop = '0; b3.cfg_we = 1'b0; b3.cfg_idx = '0; b3.cfg_wgt = '0; b3.out_ready = 1'b0;

      // Reset state, first-packet latency and back-pressure hold.
      do_reset();
      chk("rst_pop", 64'(b.pop), 64'd0);
      chk("rst_valid", 64'(b.out_valid), 64'd0);
      chk("rst_data", 64'(b.out_data), 64'd0);
      chk("rst_src", 64'(b.out_src), 64'd0);
      b.D_pop[0 +: PW] = 16'hA5A5; b.D_pop[PW +: PW] = 16'h5A5A;
      b.pndng = 4'b0001;
      tick();
      chk("lat_pop", {59'd0, b.pop, b.out_valid}, {59'd0, 4'b0001, 1'b0});
      b.pndng = 4'b0010;
      tick();
      chk("lat_out", {b.pop, b.out_valid, b.out_data, b.out_src}, {4'b0000, 1'b1, 16'hA5A5, 2'd0});
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("stall_hold", {b.pop, b.out_valid, b.out_data, b.out_src}, {4'b0000, 1'b1, 16'hA5A5, 2'd0});
      end
      b.out_ready = 1'b1;
      tick();
      chk("stall_accept", 64'(b.out_valid), 64'd0);
      tick();
      chk("stall_next_pop", 64'(b.pop), 64'b0010);

      // Grant-order table.
      for (int v = 0; v < 6; v++) begin
         b.pndng = '0; b.out_ready = 1'b0;
         do_reset();
         set_pattern();
         for (int i = 0; i < N; i++) wr(i, int'(vecs[v].wgt[4*i +: 4]));
         b.out_ready = 1'b1;
         b.pndng = vecs[v].pend;
         collect(9);
         e = vecs[v].exp;
         for (int k = 0; k < 9 && k < got_src.size(); k++) begin
            chk($sformatf("tbl%0d_src%0d", v, k), 64'(got_src[k]), 64'(e[4*k +: 4]));
            chk($sformatf("tbl%0d_dat%0d", v, k), 64'(got_dat[k]), 64'(16'hC000 + 16'(e[4*k +: 4])));
         end
      end

      // Reset during SEND, with a colliding weight write that reset must override.
      b.pndng = '0; b.out_ready = 1'b0;
      do_reset();
      wr(0, 3);
      b.pndng = 4'hF;
      waitc = 0;
      while (!b.out_valid && waitc < 20) begin tick(); waitc++; end
      chk("rst_mid_reach_send", 64'(b.out_valid), 64'd1);
      reset = 1'b1; b.cfg_we = 1'b1; b.cfg_idx = 2'd0; b.cfg_wgt = 4'd3;
      tick();
      reset = 1'b0; b.cfg_we = 1'b0;
      chk("rst_mid_out", {59'd0, b.pop, b.out_valid}, 64'd0);
      b.out_ready = 1'b1;
      collect(3);
      for (int k = 0; k < 3 && k < got_src.size(); k++)
         chk($sformatf("rst_mid_src%0d", k), 64'(got_src[k]), 64'(k));

      // Out-of-range cfg_idx on the 3-requester instance is ignored.
      b.pndng = '0;
      for (int i = 0; i < 3; i++) b3.D_pop[i*PW +: PW] = 16'hB000 + 16'(i);
      b3.cfg_we = 1'b1; b3.cfg_idx = 2'd3; b3.cfg_wgt = 4'd0; tick();
      b3.cfg_idx = 2'd1; b3.cfg_wgt = 4'd2; tick();
      b3.cfg_we = 1'b0;
      b3.pndng = 3'b111; b3.out_ready = 1'b1;
      got_src.delete();
      for (int c = 0; c < 200 && got_src.size() < 5; c++) begin
         tick();
         if (b3.out_valid) got_src.push_back(int'(b3.out_src));
      end
      if (got_src.size() < 5) chk("oor_timeout", 64'(got_src.size()), 64'd5);
      e = 36'h0_0000_0210;
      e[4 +: 4] = 4'd1; e[8 +: 4] = 4'd1; e[12 +: 4] = 4'd2; e[16 +: 4] = 4'd0; e[0 +: 4] = 4'd0;
      for (int k = 0; k < 5 && k < got_src.size(); k++)
         chk($sformatf("oor_src%0d", k), 64'(got_src[k]), 64'(e[4*k +: 4]));
      b3.pndng = '0;

      // Random traffic, config writes and back-pressure against the model.
      b.pndng = '0; b.out_ready = 1'b0; b.cfg_we = 1'b0;
      do_reset();
      m_init();
      for (int c = 0; c < 800; c++) begin
         b.pndng = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
         b.out_ready = 1'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) b.D_pop[i*PW +: PW] = 16'($urandom);
         b.cfg_we = ($urandom_range(0, 7) == 0);
         b.cfg_idx = 2'($urandom_range(0, N-1));
         b.cfg_wgt = 4'($urandom_range(0, 3));
         m_step(ep, ev);
         tick();
         chk("rnd_ctl", {59'd0, b.pop, b.out_valid}, {59'd0, ep, ev});
         if (ev) chk("rnd_pkt", {46'd0, b.out_data, b.out_src}, {46'd0, m_data, 2'(m_src)});
      end
      b.cfg_we = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
